// File: rtl/rr_mux_arbiter.sv
// rr_mux_arbiter: round-robin arbiter in front of a shared N:1 data mux.
// The arbiter picks one valid requester per cycle, starting its scan at a
// rotating priority pointer. It loads that requester's word into a
// one-entry output register with valid/ready handshakes on both sides.
// The mux select is generated internally from the winner index, so it
// can never be left floating or ignored by the datapath.
module rr_mux_arbiter #(
  parameter int N    = 4,
  parameter int W    = 8,
  parameter int SELW = (N > 1) ? $clog2(N) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N-1:0]      req_valid,
  input  logic [N*W-1:0]    req_data,
  output logic [N-1:0]      req_ready,
  output logic              out_valid,
  output logic [W-1:0]      out_data,
  input  logic              out_ready,
  output logic [SELW-1:0]   out_sel,
  output logic [N-1:0]      grant
);

  // Registered state: output word, its source index, and the priority pointer.
  logic            out_valid_q, out_valid_d;
  logic [W-1:0]    out_data_q,  out_data_d;
  logic [SELW-1:0] out_sel_q,   out_sel_d;
  logic [SELW-1:0] ptr_q,       ptr_d;

  // Arbitration results.
  logic            win_found;
  logic [SELW-1:0] win_idx;
  logic            can_accept;
  logic            xfer;

  // The output register can take a new word when it is empty or being drained.
  assign can_accept = !out_valid_q || out_ready;

  // A transfer needs a winner, room in the output register and reset released.
  assign xfer = rst_n && win_found && can_accept;

  // Scan ptr, ptr+1, ... (mod N) and take the first requester with valid set.
  always_comb begin
    int idx;
    win_found = 1'b0;
    win_idx   = '0;
    idx       = 0;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= N) begin
        idx = idx - N;
      end
      if (!win_found && req_valid[idx]) begin
        win_found = 1'b1;
        win_idx   = SELW'(idx);
      end
    end
  end

  // Only the winner sees ready, and only when the output register has room.
  // Ready is held low while reset is asserted so no handshake completes then.
  always_comb begin
    req_ready = '0;
    if (xfer) begin
      req_ready[win_idx] = 1'b1;
    end
  end

  // Next-state: load on transfer, clear valid on a pure drain, otherwise hold.
  always_comb begin
    int nxt;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    ptr_d       = ptr_q;
    nxt         = int'(win_idx) + 1;
    if (nxt >= N) begin
      nxt = 0;
    end
    if (xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = req_data[int'(win_idx)*W +: W];
      out_sel_d   = win_idx;
      ptr_d       = SELW'(nxt);
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // State register; synchronous reset discards any pending word and rewinds ptr.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
      ptr_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      ptr_q       <= ptr_d;
    end
  end

  // Grant is the one-hot form of the registered select while a word is held.
  always_comb begin
    grant = '0;
    if (out_valid_q) begin
      grant[out_sel_q] = 1'b1;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Testbench for rr_mux_arbiter: directed scenarios followed by random
// traffic, all compared against a behavioural round-robin model.
module tb_rr_mux_arbiter;
  localparam int N    = 4;
  localparam int W    = 8;
  localparam int SELW = 2;

  logic            clk;
  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [N*W-1:0]  req_data;
  logic [N-1:0]    req_ready;
  logic            out_valid;
  logic [W-1:0]    out_data;
  logic            out_ready;
  logic [SELW-1:0] out_sel;
  logic [N-1:0]    grant;

  int checks;
  int failures;

  // Behavioural model state
  int m_ptr;
  int m_valid;
  int m_data;
  int m_sel;

  rr_mux_arbiter #(.N(N), .W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .out_sel   (out_sel),
    .grant     (grant)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // First requester with valid set, scanning from the model pointer; -1 if none.
  function automatic int model_winner();
    int idx;
    for (int k = 0; k < N; k++) begin
      idx = (m_ptr + k) % N;
      if (req_valid[idx]) return idx;
    end
    return -1;
  endfunction

  // One clock cycle: check combinational ready, clock, update model, check outputs.
  task automatic step();
    int w;
    logic [N-1:0] exp_rdy;
    logic [N-1:0] exp_gnt;
    #1;
    w = model_winner();
    exp_rdy = '0;
    if (rst_n && w >= 0 && (m_valid == 0 || out_ready)) exp_rdy[w] = 1'b1;
    chk("req_ready", 32'(req_ready), 32'(exp_rdy));
    @(posedge clk);
    if (!rst_n) begin
      m_ptr = 0; m_valid = 0; m_data = 0; m_sel = 0;
    end else if (w >= 0 && (m_valid == 0 || out_ready)) begin
      m_valid = 1;
      m_data  = int'(req_data[w*W +: W]);
      m_sel   = w;
      m_ptr   = (w + 1) % N;
    end else if (m_valid != 0 && out_ready) begin
      m_valid = 0;
    end
    #1;
    exp_gnt = '0;
    if (m_valid != 0) exp_gnt[m_sel] = 1'b1;
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    chk("out_data",  32'(out_data),  32'(m_data));
    chk("out_sel",   32'(out_sel),   32'(m_sel));
    chk("grant",     32'(grant),     32'(exp_gnt));
  endtask

  initial begin
    checks = 0; failures = 0;
    m_ptr = 0; m_valid = 0; m_data = 0; m_sel = 0;
    rst_n = 1'b0; out_ready = 1'b1; req_valid = '1;
    req_data = {8'h13, 8'h12, 8'h11, 8'h10};

    // Reset with all requesters valid
    step();
    step();
    chk("rst_ready", 32'(req_ready), 32'h0);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_out_data", 32'(out_data), 32'h0);
    chk("rst_grant", 32'(grant), 32'h0);

    // Rotation with all valid: first transfer from requester 0
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("rot_data", 32'(out_data), 32'h10 + 32'(i % 4));
      chk("rot_sel", 32'(out_sel), 32'(i % 4));
    end

    // Select honoured
    req_valid = 4'b0100; req_data = {8'h00, 8'hA5, 8'h00, 8'h00};
    step();
    chk("sel2_data", 32'(out_data), 32'hA5);
    chk("sel2_sel", 32'(out_sel), 32'd2);
    req_valid = 4'b0010; req_data = {8'h00, 8'h00, 8'h3C, 8'h00};
    step();
    chk("sel1_data", 32'(out_data), 32'h3C);
    chk("sel1_sel", 32'(out_sel), 32'd1);

    // Backpressure
    req_valid = 4'b0001; req_data = {8'h00, 8'h00, 8'h00, 8'h55};
    step();
    chk("bp_load", 32'(out_data), 32'h55);
    req_valid = 4'b0010; req_data = {8'h00, 8'h00, 8'h66, 8'h55};
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_ready", 32'(req_ready), 32'h0);
      step();
      chk("bp_hold_data", 32'(out_data), 32'h55);
      chk("bp_hold_valid", 32'(out_valid), 32'h1);
    end
    out_ready = 1'b1;
    step();
    chk("bp_release_data", 32'(out_data), 32'h66);
    chk("bp_release_valid", 32'(out_valid), 32'h1);

    // Skip and wrap: grant to 2 puts ptr at 3, then 0 and 1 win
    req_valid = 4'b0100; req_data = {8'h04, 8'h03, 8'h02, 8'h01};
    step();
    chk("wrap_g2", 32'(out_sel), 32'd2);
    req_valid = 4'b0011;
    step();
    chk("wrap_g0", 32'(out_sel), 32'd0);
    step();
    chk("wrap_g1", 32'(out_sel), 32'd1);
    req_valid = 4'b1111;
    step();
    chk("wrap_ptr2", 32'(out_sel), 32'd2);

    // Reset mid-stall: held word discarded, ptr back to 0
    out_ready = 1'b0;
    step();
    rst_n = 1'b0;
    step();
    chk("rst_stall_valid", 32'(out_valid), 32'h0);
    rst_n = 1'b1; out_ready = 1'b1;
    step();
    chk("rst_stall_first", 32'(out_sel), 32'd0);

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      req_valid = N'($urandom_range(0, (1 << N) - 1));
      req_data  = (N*W)'($urandom);
      out_ready = ($urandom_range(0, 9) < 7);
      rst_n     = ($urandom_range(0, 99) != 0);
      step();
    end

    // Drain
    rst_n = 1'b1; req_valid = '0; out_ready = 1'b1;
    step();
    step();
    chk("drain_valid", 32'(out_valid), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
